alu_dserial_addsub: RTL and testbench

Digit-serial add/subtract unit for the ALU datapath. It drives a 2-bit carry-select adder slice with its operand and carry inputs and collects the slice's sum and carry outputs. A WIDTH-bit add or subtract is performed 2 bits per cycle over WIDTH/2 cycles. A start/busy/done handshake lets the ALU control logic issue operations back-to-back without a wide parallel adder.

---
 rtl/alu_dserial_addsub.sv | 125 ++++++++++++
 tb/tb_alu_dserial_addsub.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_dserial_addsub.sv
// Digit-serial add/subtract: WIDTH-bit add or subtract, 2 bits per cycle.
// Drives a 2-bit carry-select slice and collects its sum and carry.
module alu_dserial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_r_q, c_r_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [1:0] s0, s1, s;
  logic       co0, co1, co;
  logic       accept, last;

  // Carry-select slice: both carry-in cases in parallel, c_r picks one
  always_comb begin
    {co0, s0} = {1'b0, a_sh_q[1:0]} + {1'b0, b_sh_q[1:0]};
    {co1, s1} = {1'b0, a_sh_q[1:0]} + {1'b0, b_sh_q[1:0]} + 3'd1;
    s  = c_r_q ? s1 : s0;
    co = c_r_q ? co1 : co0;
  end

  assign accept = start && (state_q != RUN);
  assign last   = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    cnt_d    = cnt_q;
    c_r_d    = c_r_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      RUN: begin
        sum_sh_d = (sum_sh_q >> 2) | (WIDTH'(s) << (WIDTH - 2));
        a_sh_d   = a_sh_q >> 2;
        b_sh_d   = b_sh_q >> 2;
        c_r_d    = co;
        cnt_d    = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          // s[1] becomes the result MSB on this edge
          ovf_d   = (a_msb_q == b_msb_q) && (s[1] != a_msb_q);
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          state_d = RUN;
          a_sh_d  = inA;
          b_sh_d  = sub ? ~inB : inB;
          c_r_d   = sub;
          cnt_d   = '0;
          a_msb_d = inA[WIDTH-1];
          b_msb_d = inB[WIDTH-1] ^ sub;
        end
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      cnt_q    <= '0;
      c_r_q    <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      cnt_q    <= cnt_d;
      c_r_q    <= c_r_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_sh_q;
  assign cout = c_r_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_alu_dserial_addsub.sv
// Bench for alu_dserial_addsub: WIDTH=8 and WIDTH=2 instances,
// table vectors, handshake/reset sequences and randomized ops.
module tb_alu_dserial_addsub;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sub;
  logic [7:0] inA, inB;
  bit         sel;

  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] sum2;
  logic       start8, start2;
  logic [1:0] inA2, inB2;

  logic       cur_busy, cur_done, cur_cout, cur_ovf;
  logic [7:0] cur_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign start8 = start & ~sel;
  assign start2 = start & sel;
  assign inA2   = inA[1:0];
  assign inB2   = inB[1:0];

  alu_dserial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub),
    .inA(inA), .inB(inB), .busy(busy8), .done(done8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  alu_dserial_addsub #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub),
    .inA(inA2), .inB(inB2), .busy(busy2), .done(done2),
    .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  always_comb begin
    cur_busy = sel ? busy2 : busy8;
    cur_done = sel ? done2 : done8;
    cur_cout = sel ? cout2 : cout8;
    cur_ovf  = sel ? ovf2 : ovf8;
    cur_sum  = sel ? {6'b0, sum2} : sum8;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: integer arithmetic on unsigned and signed views
  function automatic void model(input int w, input int a, input int b,
                                input bit s, output int rs,
                                output bit rc, output bit rv);
    int m, sa, sb, r, sr;
    m  = 1 << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    r  = s ? a - b : a + b;
    sr = s ? sa - sb : sa + sb;
    rs = ((r % m) + m) % m;
    rc = s ? (a >= b) : (r >= m);
    rv = (sr >= m / 2) || (sr < -(m / 2));
  endfunction

  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input bit s);
    start = 1'b1;
    inA   = a;
    inB   = b;
    sub   = s;
  endtask

  // Accepting edge is the next posedge; returns at #1 into the done cycle
  task automatic wait_done(input int es, input bit ec, input bit ev,
                           input bit mid, input string tag);
    int lat;
    int n;
    lat = 0;
    n   = sel ? 1 : 4;
    @(posedge clk);
    #1;
    start = 1'b0;
    inA   = 8'($urandom);
    inB   = 8'($urandom);
    chk({tag, "_busy_after_accept"}, cur_busy, 1);
    while (!cur_done && lat < 20) begin
      chk({tag, "_overlap"}, cur_busy & cur_done, 0);
      start = mid && (lat == 1);
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, lat, n);
    chk({tag, "_done_busy"}, cur_busy, 0);
    chk({tag, "_sum"}, cur_sum, es);
    chk({tag, "_cout"}, cur_cout, ec);
    chk({tag, "_ovf"}, cur_ovf, ev);
  endtask

  task automatic after_done(input int es, input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, cur_done, 0);
    chk({tag, "_sum_hold"}, cur_sum, es);
  endtask

  typedef struct {
    int         w;
    logic [7:0] a;
    logic [7:0] b;
    bit         s;
    logic [7:0] es;
    bit         ec;
    bit         ev;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int  rs;
    bit  rc, rv;
    int  w;
    logic [7:0] a, b, msk;
    bit  s;

    tbl[0] = '{8, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    tbl[1] = '{8, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
    tbl[3] = '{8, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[4] = '{2, 8'h03, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[5] = '{8, 8'h7F, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0};

    rst   = 1'b1;
    start = 1'b1;
    sub   = 1'b0;
    inA   = 8'h5A;
    inB   = 8'h3C;
    sel   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_sum8", sum8, 0);
    chk("rst_cout8", cout8, 0);
    chk("rst_ovf8", ovf8, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_sum2", sum2, 0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      sel = (tbl[i].w == 2);
      @(negedge clk);
      issue(tbl[i].a, tbl[i].b, tbl[i].s);
      wait_done(tbl[i].es, tbl[i].ec, tbl[i].ev, 1'b0, $sformatf("vec%0d", i));
      after_done(tbl[i].es, $sformatf("vec%0d", i));
    end

    sel = 1'b0;
    @(negedge clk);
    issue(8'h5A, 8'h3C, 1'b0);
    wait_done(8'h96, 1'b0, 1'b1, 1'b1, "midstart");
    after_done(8'h96, "midstart");

    @(negedge clk);
    issue(8'hFF, 8'h01, 1'b0);
    wait_done(8'h00, 1'b1, 1'b0, 1'b0, "b2b_first");
    issue(8'h80, 8'h01, 1'b1);
    wait_done(8'h7F, 1'b1, 1'b1, 1'b0, "b2b_second");
    after_done(8'h7F, "b2b_second");

    @(negedge clk);
    issue(8'h5A, 8'h3C, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", busy8, 0);
    chk("midrst_done", done8, 0);
    chk("midrst_sum", sum8, 0);
    chk("midrst_cout", cout8, 0);
    chk("midrst_ovf", ovf8, 0);
    begin
      bit seen;
      seen = 1'b0;
      repeat (8) begin
        @(posedge clk);
        #1;
        seen |= done8;
      end
      chk("midrst_no_done", seen, 0);
    end

    for (int i = 0; i < 60; i++) begin
      sel = (i % 4 == 3);
      w   = sel ? 2 : 8;
      msk = sel ? 8'h03 : 8'hFF;
      a   = 8'($urandom) & msk;
      b   = 8'($urandom) & msk;
      s   = 1'($urandom);
      model(w, int'(a), int'(b), s, rs, rc, rv);
      @(negedge clk);
      issue(a, b, s);
      wait_done(rs, rc, rv, 1'($urandom), $sformatf("rnd%0d", i));
      after_done(rs, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
